tx_pkt_ctrl: RTL

TX_PKT_CTRL -- requirements
Module: tx_pkt_ctrl

---
 rtl/tx_pkt_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tx_pkt_ctrl
//  Description : Packet transmit sequencer. On an accepted start it walks a
//                shift register / bit-timer pair through SYNC (8'h80), PID
//                ({~pid,pid}), data_len payload bytes popped from a
//                first-word-fall-through FIFO, then an EOP made of two bit
//                periods of SE0 and one bit period of forced J. A FIFO
//                underrun aborts straight into EOP with a tx_err pulse.
//                stall freezes the whole sequence in place.
//
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start, pid,       - packet request and its parameters,
//                data_len            sampled only in IDLE
//                stall             - freeze request (mirrored on pause)
//                fifo_empty,       - TX FIFO status / head byte / pop
//                fifo_rdata,
//                fifo_read
//                byte_done,        - bit-timer events
//                bit_ready
//                sending, clear,   - bit-timer controls
//                pause
//                load_en,          - shift-register parallel load
//                load_data
//                se0, force_j      - line-encoder EOP overrides
//                tx_busy, tx_done, - status
//                tx_err
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_pkt_ctrl #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic [6:0] data_len,
    input  logic       stall,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_read,
    input  logic       byte_done,
    input  logic       bit_ready,
    output logic       sending,
    output logic       clear,
    output logic       pause,
    output logic       load_en,
    output logic [7:0] load_data,
    output logic       se0,
    output logic       force_j,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [6:0] c_max_len   = 7'(MAX_LEN);
    localparam logic [7:0] c_sync_byte = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_SYNC = 4'd1,
        S_TX_SYNC = 4'd2,
        S_LD_PID  = 4'd3,
        S_TX_PID  = 4'd4,
        S_LD_DATA = 4'd5,
        S_TX_DATA = 4'd6,
        S_EOP_SE0 = 4'd7,
        S_EOP_J   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t     r_state;
    logic [3:0] r_pid;
    logic [6:0] r_remaining;   // payload bytes still to be loaded
    logic [1:0] r_bit_cnt;     // SE0 bit periods already elapsed

    logic [6:0] w_clamped_len;

    assign w_clamped_len = (data_len > c_max_len) ? c_max_len : data_len;

    // ------------------------------------------------------------------------
    // Sequencer. IDLE is evaluated ahead of the stall gate so a request made
    // while stalled is still captured; everything after it waits for stall=0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pid       <= 4'h0;
            r_remaining <= 7'd0;
            r_bit_cnt   <= 2'd0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_state     <= S_LD_SYNC;
                r_pid       <= pid;
                r_remaining <= w_clamped_len;
                r_bit_cnt   <= 2'd0;
            end
        end else if (!stall) begin
            unique case (r_state)
                S_LD_SYNC: r_state <= S_TX_SYNC;
                S_TX_SYNC: begin
                    if (byte_done) begin
                        r_state <= S_LD_PID;
                    end
                end
                S_LD_PID:  r_state <= S_TX_PID;
                S_TX_PID, S_TX_DATA: begin
                    if (byte_done) begin
                        r_state <= (r_remaining != 7'd0) ? S_LD_DATA : S_EOP_SE0;
                    end
                end
                S_LD_DATA: begin
                    // An empty FIFO here is an underrun: abort into EOP.
                    if (!fifo_empty) begin
                        r_state     <= S_TX_DATA;
                        r_remaining <= r_remaining - 7'd1;
                    end else begin
                        r_state <= S_EOP_SE0;
                    end
                end
                S_EOP_SE0: begin
                    if (bit_ready) begin
                        if (r_bit_cnt == 2'd1) begin
                            r_bit_cnt <= 2'd0;
                            r_state   <= S_EOP_J;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 2'd1;
                        end
                    end
                end
                S_EOP_J: begin
                    if (bit_ready) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_bit_cnt <= 2'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line-facing controls decode the state register only, so they cannot
    // glitch on input activity.
    assign sending = (r_state == S_TX_SYNC) || (r_state == S_TX_PID) ||
                     (r_state == S_TX_DATA) || (r_state == S_EOP_SE0) ||
                     (r_state == S_EOP_J);
    assign se0     = (r_state == S_EOP_SE0);
    assign force_j = (r_state == S_EOP_J);
    assign tx_busy = (r_state != S_IDLE);
    assign clear   = (r_state == S_LD_SYNC) || (r_state == S_DONE);

    // IDLE is excluded so that the block shows all-zero outputs between
    // packets even when stall is held.
    assign pause   = stall && (r_state != S_IDLE);

    // One-shot strobes are suppressed while stalled so that a frozen load or
    // completion state does not repeat its action every cycle.
    always_comb begin
        load_en   = 1'b0;
        load_data = 8'h00;
        fifo_read = 1'b0;
        tx_done   = 1'b0;
        tx_err    = 1'b0;
        if (!stall) begin
            unique case (r_state)
                S_LD_SYNC: begin
                    load_en   = 1'b1;
                    load_data = c_sync_byte;
                end
                S_LD_PID: begin
                    load_en   = 1'b1;
                    load_data = {~r_pid, r_pid};
                end
                S_LD_DATA: begin
                    if (!fifo_empty) begin
                        load_en   = 1'b1;
                        load_data = fifo_rdata;
                        fifo_read = 1'b1;
                    end else begin
                        tx_err = 1'b1;
                    end
                end
                S_DONE:  tx_done = 1'b1;
                default: load_en = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire
